// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Sequences an external 8-bit load/shift register. A request (operand,
//   amount, arith) is accepted on start while ready. The operand is loaded,
//   shifted right once per cycle for the effective amount, and the shifter
//   output is then registered into result and flagged with a one-cycle done.
//
// Ports
//   clk, reset              clock, async active-high reset
//   start, operand, amount, arith   request (sampled only while ready)
//   shifter_q               shifter register output
//   load_val, load_n, shift_right, asr   shifter controls
//   ready, done, result     handshake / registered result
//
// Configuration
//   SHIFT_CLAMP_EN  defined: amount >= 8 clamps to 8 (full shift-out).
//                   undefined: amount is taken modulo 8.
module shift_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] operand,
  input  logic [3:0] amount,
  input  logic       arith,
  input  logic [7:0] shifter_q,
  output logic [7:0] load_val,
  output logic       load_n,
  output logic       shift_right,
  output logic       asr,
  output logic       ready,
  output logic       done,
  output logic [7:0] result
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_CAPTURE, S_DONE
  } state_t;

  state_t     state, state_nx;
  logic [3:0] count;
  logic       arith_r;
  logic [3:0] eff_amount;

  always_comb begin
`ifdef SHIFT_CLAMP_EN
    eff_amount = amount[3] ? 4'd8 : amount;
`else
    eff_amount = {1'b0, amount[2:0]};
`endif
  end

  // State register plus the datapath registers that move with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= 4'd0;
      load_val <= 8'h00;
      arith_r  <= 1'b0;
      result   <= 8'h00;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          load_val <= operand;
          count    <= eff_amount;
          arith_r  <= arith;
        end
        S_SHIFT:   count  <= count - 4'd1;
        S_CAPTURE: result <= shifter_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = S_LOAD;
      S_LOAD:    state_nx = (count == 4'd0) ? S_CAPTURE : S_SHIFT;
      S_SHIFT:   if (count == 4'd1) state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Moore outputs. asr stays 1 everywhere except a logical shift, because
  // the shifter clears its MSB whenever asr=0 while not loading.
  always_comb begin
    ready       = 1'b0;
    done        = 1'b0;
    load_n      = 1'b1;
    shift_right = 1'b0;
    asr         = 1'b1;
    case (state)
      S_IDLE:  ready = 1'b1;
      S_LOAD:  load_n = 1'b0;
      S_SHIFT: begin
        shift_right = 1'b1;
        asr         = arith_r;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] operand;
  logic [3:0] amount;
  logic       arith;
  logic [7:0] shifter_q;
  logic [7:0] load_val;
  logic       load_n, shift_right, asr, ready, done;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;

  shift_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .operand(operand),
    .amount(amount), .arith(arith), .shifter_q(shifter_q),
    .load_val(load_val), .load_n(load_n), .shift_right(shift_right),
    .asr(asr), .ready(ready), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Behavioural model of the downstream load/shift register.
  initial shifter_q = 8'h00;
  always @(posedge clk) begin
    if (!load_n)          shifter_q <= load_val;
    else if (shift_right) shifter_q <= {asr ? shifter_q[7] : 1'b0, shifter_q[7:1]};
    else if (!asr)        shifter_q[7] <= 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] op;
    logic [3:0] amt;
    logic       ar;
    logic [7:0] exp_res;
    int         shifts;
  } vec_t;

  vec_t vecs[10];

  // One full transaction with latency, control-pulse and asr-rule checks.
  task automatic run(input string name, input logic [7:0] op, input logic [3:0] amt,
                     input logic ar, input logic [7:0] exp_res, input int exp_sh);
    int lat, sh, ln;
    bit seen, asr_ok;
    @(negedge clk);
    chk({name, " ready"}, ready, 1);
    operand = op; amount = amt; arith = ar; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; operand = ~op; amount = ~amt; arith = ~ar;
    lat = 0; sh = 0; ln = 0; seen = 0; asr_ok = 1;
    while (!seen && lat < 40) begin
      @(negedge clk);
      if (shift_right) sh++;
      if (!load_n) ln++;
      if (shift_right && !ar) begin
        if (asr !== 1'b0) asr_ok = 0;
      end else if (asr !== 1'b1) asr_ok = 0;
      if (done) seen = 1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    chk({name, " done_seen"}, seen, 1);
    chk({name, " latency"}, lat, exp_sh + 2);
    chk({name, " shifts"}, sh, exp_sh);
    chk({name, " load_pulses"}, ln, 1);
    chk({name, " asr_rule"}, asr_ok, 1);
    chk({name, " result"}, result, exp_res);
    @(negedge clk);
    chk({name, " done_low"}, done, 0);
    chk({name, " ready_back"}, ready, 1);
  endtask

  initial begin
    int dones;
    vecs[0] = '{8'hB4, 4'd2, 1'b0, 8'h2D, 2};
    vecs[1] = '{8'hB4, 4'd3, 1'b1, 8'hF6, 3};
    vecs[2] = '{8'hB4, 4'd0, 1'b0, 8'hB4, 0};
    vecs[3] = '{8'h80, 4'd0, 1'b0, 8'h80, 0};
    vecs[4] = '{8'hFF, 4'd1, 1'b0, 8'h7F, 1};
    vecs[5] = '{8'h7F, 4'd7, 1'b1, 8'h00, 7};
`ifdef SHIFT_CLAMP_EN
    vecs[6] = '{8'h80, 4'd12, 1'b0, 8'h00, 8};
    vecs[7] = '{8'h80, 4'd12, 1'b1, 8'hFF, 8};
    vecs[8] = '{8'h80, 4'd8,  1'b0, 8'h00, 8};
    vecs[9] = '{8'h81, 4'd15, 1'b0, 8'h00, 8};
`else
    vecs[6] = '{8'h80, 4'd12, 1'b0, 8'h08, 4};
    vecs[7] = '{8'h80, 4'd12, 1'b1, 8'hF8, 4};
    vecs[8] = '{8'h80, 4'd8,  1'b0, 8'h80, 0};
    vecs[9] = '{8'h81, 4'd15, 1'b0, 8'h01, 7};
`endif

    reset = 1'b1; start = 1'b0; operand = 8'h00; amount = 4'd0; arith = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", ready, 1);
    chk("rst load_n", load_n, 1);
    chk("rst shift_right", shift_right, 0);
    chk("rst asr", asr, 1);
    chk("rst done", done, 0);
    chk("rst result", result, 8'h00);
    chk("rst load_val", load_val, 8'h00);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      run($sformatf("vec%0d", i), vecs[i].op, vecs[i].amt, vecs[i].ar,
          vecs[i].exp_res, vecs[i].shifts);

    // start pulsed during SHIFT must be ignored.
    @(negedge clk);
    operand = 8'hB4; amount = 4'd3; arith = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("ign in_shift", shift_right, 1);
    operand = 8'h11; amount = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        dones++;
        chk("ign result", result, 8'h16);
      end
      @(negedge clk);
    end
    chk("ign one_done", dones, 1);

    // Reset asserted during SHIFT.
    operand = 8'hF0; amount = 4'd5; arith = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid in_shift", shift_right, 1);
    reset = 1'b1; #1;
    chk("mid ready", ready, 1);
    chk("mid load_n", load_n, 1);
    chk("mid shift_right", shift_right, 0);
    chk("mid result", result, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("mid no_done", dones, 0);
    run("after_rst", 8'hC3, 4'd2, 1'b1, 8'hF0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
